// File: rtl/instr_trace_buffer_if.sv
// Bus bundle for instr_trace_buffer: retire tap, trigger and control inputs, debug read port.
interface instr_trace_buffer_if #(
  parameter int unsigned AW    = 4,
  parameter int unsigned CNT_W = 16
) ();
  logic             ret_valid;
  logic [31:0]      ret_pc;
  logic [31:0]      ret_instr;
  logic [31:0]      ret_wd;
  logic             clear;
  logic             trig_en;
  logic [31:0]      trig_pc;
  logic [AW-1:0]    rd_idx;
  logic [3:0]       rd_class;
  logic [31:0]      rd_pc;
  logic [31:0]      rd_instr;
  logic [31:0]      rd_wd;
  logic [CNT_W-1:0] class_cnt;
  logic [AW:0]      entry_cnt;
  logic             wrapped;
  logic             frozen;
  logic             triggered;

  modport master (
    output ret_valid, ret_pc, ret_instr, ret_wd, clear, trig_en, trig_pc, rd_idx, rd_class,
    input  rd_pc, rd_instr, rd_wd, class_cnt, entry_cnt, wrapped, frozen, triggered
  );

  modport slave (
    input  ret_valid, ret_pc, ret_instr, ret_wd, clear, trig_en, trig_pc, rd_idx, rd_class,
    output rd_pc, rd_instr, rd_wd, class_cnt, entry_cnt, wrapped, frozen, triggered
  );
endinterface

// File: rtl/instr_trace_buffer.sv
// Circular retire-trace capture with per-class counters and PC-match trigger/freeze.
// Optional TRACE_SELF_JUMP_HALT_EN: freeze after capturing a J that jumps to itself.
module instr_trace_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  instr_trace_buffer_if.slave bus
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_POST   = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);

  logic [1:0]       state, state_nxt;
  logic [AW-1:0]    post_cnt, post_cnt_nxt;
  logic             trig_set;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      entry_cnt;
  logic             wrapped;
  logic             triggered;
  logic [CNT_W-1:0] cnt [16];
  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [31:0]      mem_wd    [DEPTH];

  logic             soft_rst;
  logic             cap;
  logic             match;
  logic             self_jmp;
  logic             cls_vld;
  logic [3:0]       cls;
  logic [5:0]       op;
  logic [5:0]       fn;
  logic [AW-1:0]    rd_phys;
  logic             rd_hit;

  assign soft_rst = rst | bus.clear;
  assign cap      = bus.ret_valid && (state != ST_FROZEN);
  assign match    = bus.trig_en && (bus.ret_pc == bus.trig_pc);
  assign op       = bus.ret_instr[31:26];
  assign fn       = bus.ret_instr[5:0];

`ifdef TRACE_SELF_JUMP_HALT_EN
  assign self_jmp = (op == 6'd2) &&
                    ({bus.ret_pc[31:28], bus.ret_instr[25:0], 2'b00} == bus.ret_pc);
`else
  assign self_jmp = 1'b0;
`endif

  // Retired-instruction class decode
  always_comb begin
    cls     = 4'd0;
    cls_vld = 1'b1;
    case (op)
      6'd0: begin
        case (fn)
          6'd32:   cls = 4'd0;
          6'd34:   cls = 4'd1;
          6'd36:   cls = 4'd2;
          6'd37:   cls = 4'd3;
          6'd42:   cls = 4'd4;
          6'd0:    cls = (bus.ret_instr == 32'd0) ? 4'd5 : 4'd6;
          6'd25:   cls = 4'd7;
          6'd16:   cls = 4'd8;
          6'd18:   cls = 4'd9;
          default: cls_vld = 1'b0;
        endcase
      end
      6'd35:   cls = 4'd10;
      6'd43:   cls = 4'd11;
      6'd4:    cls = 4'd12;
      6'd2:    cls = 4'd13;
      6'd8:    cls = 4'd14;
      6'd12:   cls = 4'd15;
      default: cls_vld = 1'b0;
    endcase
  end

  // Trigger / post-capture / freeze next-state
  always_comb begin
    state_nxt    = state;
    post_cnt_nxt = post_cnt;
    trig_set     = 1'b0;
    if (cap) begin
      case (state)
        ST_RUN: begin
          if (match) begin
            trig_set     = 1'b1;
            post_cnt_nxt = AW'(POST_TRIG);
            state_nxt    = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          post_cnt_nxt = post_cnt - AW'(1);
          if (post_cnt == AW'(1)) state_nxt = ST_FROZEN;
        end
        default: ;
      endcase
      if (self_jmp) state_nxt = ST_FROZEN;
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state     <= ST_RUN;
      post_cnt  <= '0;
      triggered <= 1'b0;
      wr_ptr    <= '0;
      entry_cnt <= '0;
      wrapped   <= 1'b0;
      for (int i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      state    <= state_nxt;
      post_cnt <= post_cnt_nxt;
      if (trig_set) triggered <= 1'b1;
      if (cap) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (entry_cnt == FULL) wrapped   <= 1'b1;
        else                   entry_cnt <= entry_cnt + (AW+1)'(1);
        if (cls_vld && (cnt[cls] != {CNT_W{1'b1}})) cnt[cls] <= cnt[cls] + CNT_W'(1);
      end
    end
  end

  // Trace storage is intentionally left uninitialised across reset/clear
  always_ff @(posedge clk) begin
    if (cap && !soft_rst) begin
      mem_pc[wr_ptr]    <= bus.ret_pc;
      mem_instr[wr_ptr] <= bus.ret_instr;
      mem_wd[wr_ptr]    <= bus.ret_wd;
    end
  end

  assign rd_phys       = wr_ptr - entry_cnt[AW-1:0] + bus.rd_idx;
  assign rd_hit        = ({1'b0, bus.rd_idx} < entry_cnt);
  assign bus.rd_pc     = rd_hit ? mem_pc[rd_phys]    : 32'd0;
  assign bus.rd_instr  = rd_hit ? mem_instr[rd_phys] : 32'd0;
  assign bus.rd_wd     = rd_hit ? mem_wd[rd_phys]    : 32'd0;
  assign bus.class_cnt = cnt[bus.rd_class];
  assign bus.entry_cnt = entry_cnt;
  assign bus.wrapped   = wrapped;
  assign bus.frozen    = (state == ST_FROZEN);
  assign bus.triggered = triggered;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed bench for instr_trace_buffer against a queue-based trace model.
module tb_instr_trace_buffer;

  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wd;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_trace_buffer_if #(.AW(4), .CNT_W(16)) bus ();

  instr_trace_buffer #(.DEPTH(DEPTH), .AW(4), .CNT_W(16), .POST_TRIG(POST_TRIG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  rec_t q[$];
  int   m_cnt [16];
  bit   m_wrapped, m_frozen, m_triggered, m_post;
  int   m_left;

  logic [31:0] tbl [16] = '{
    32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825,
    32'h0022182A, 32'h00220019, 32'h00001810, 32'h00001812,
    32'h10220003, 32'h08000100, 32'h20220001, 32'h30220001,
    32'h00000021, 32'h3C010000, 32'h8C220004, 32'hAC220008
  };

  // Class of an encoding, -1 when it is not counted
  function automatic int exp_class(input logic [31:0] ins);
    logic [5:0] o, f;
    o = ins[31:26];
    f = ins[5:0];
    if (o == 6'd0) begin
      if (f == 6'd32) return 0;
      if (f == 6'd34) return 1;
      if (f == 6'd36) return 2;
      if (f == 6'd37) return 3;
      if (f == 6'd42) return 4;
      if (f == 6'd0)  return (ins == 32'd0) ? 5 : 6;
      if (f == 6'd25) return 7;
      if (f == 6'd16) return 8;
      if (f == 6'd18) return 9;
      return -1;
    end
    if (o == 6'd35) return 10;
    if (o == 6'd43) return 11;
    if (o == 6'd4)  return 12;
    if (o == 6'd2)  return 13;
    if (o == 6'd8)  return 14;
    if (o == 6'd12) return 15;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset;
    q.delete();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_wrapped = 0; m_frozen = 0; m_triggered = 0; m_post = 0; m_left = 0;
  endtask

  task automatic model_capture(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] wd);
    int c;
    if (m_frozen) return;
    q.push_back('{pc: pc, instr: ins, wd: wd});
    if (q.size() > DEPTH) begin
      void'(q.pop_front());
      m_wrapped = 1;
    end
    c = exp_class(ins);
    if (c >= 0 && m_cnt[c] < 65535) m_cnt[c]++;
    if (m_post) begin
      m_left--;
      if (m_left == 0) m_frozen = 1;
    end else if (!m_triggered && bus.trig_en && pc == bus.trig_pc) begin
      m_triggered = 1;
      if (POST_TRIG == 0) m_frozen = 1;
      else begin
        m_post = 1;
        m_left = POST_TRIG;
      end
    end
`ifdef TRACE_SELF_JUMP_HALT_EN
    if (ins[31:26] == 6'd2 && {pc[31:28], ins[25:0], 2'b00} == pc) m_frozen = 1;
`endif
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] wd);
    bus.ret_valid = 1'b1;
    bus.ret_pc    = pc;
    bus.ret_instr = ins;
    bus.ret_wd    = wd;
    model_capture(pc, ins, wd);
    tick();
    bus.ret_valid = 1'b0;
  endtask

  task automatic do_clear;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_reset();
  endtask

  task automatic check_flags(input string tag);
    chk($sformatf("%s entry_cnt", tag), 32'(bus.entry_cnt), 32'(q.size()));
    chk($sformatf("%s wrapped", tag),   32'(bus.wrapped),   32'(m_wrapped));
    chk($sformatf("%s frozen", tag),    32'(bus.frozen),    32'(m_frozen));
    chk($sformatf("%s triggered", tag), 32'(bus.triggered), 32'(m_triggered));
  endtask

  // Walks every read index and every class counter against the model
  task automatic check_all(input string tag);
    rec_t e;
    check_flags(tag);
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx   = 4'(i);
      bus.rd_class = 4'(i);
      #2;
      e = (i < q.size()) ? q[i] : '0;
      chk($sformatf("%s pc[%0d]", tag, i),    bus.rd_pc,    e.pc);
      chk($sformatf("%s instr[%0d]", tag, i), bus.rd_instr, e.instr);
      chk($sformatf("%s wd[%0d]", tag, i),    bus.rd_wd,    e.wd);
      chk($sformatf("%s cnt[%0d]", tag, i),   32'(bus.class_cnt), 32'(m_cnt[i]));
      @(negedge clk);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.ret_valid = 1'b0;
    bus.ret_pc    = '0;
    bus.ret_instr = '0;
    bus.ret_wd    = '0;
    bus.clear     = 1'b0;
    bus.trig_en   = 1'b0;
    bus.trig_pc   = '0;
    bus.rd_idx    = '0;
    bus.rd_class  = '0;
    model_reset();
    @(negedge clk);
    tick();
    rst = 1'b0;
    check_all("reset");

    // Basic capture: ADD, LW, SW
    retire(32'h0, 32'h00221820, 32'h11);
    retire(32'h4, 32'h8C220004, 32'h22);
    retire(32'h8, 32'hAC220008, 32'h0);
    check_all("basic");

    // Wrap-around with a mix of classes and uncounted encodings
    do_clear();
    for (int k = 0; k < 20; k++) retire(32'(4 * k), tbl[k % 16], 32'(k * 3 + 1));
    check_all("wrap");

    // PC-match trigger, post capture, freeze
    do_clear();
    bus.trig_en = 1'b1;
    bus.trig_pc = 32'h20;
    for (int k = 0; k <= 12; k++) begin
      retire(32'(4 * k), 32'h00221820, 32'(k));
      if (4 * k == 32'h20) bus.trig_en = 1'b0;
      check_flags($sformatf("trig pc%0h", 4 * k));
    end
    check_all("frozen");
    bus.trig_en = 1'b1;
    retire(32'h34, 32'h00221820, 32'h99);
    check_all("after_freeze");

    // Clear wins over a same-cycle retire while frozen
    bus.trig_en   = 1'b0;
    bus.clear     = 1'b1;
    bus.ret_valid = 1'b1;
    bus.ret_pc    = 32'h38;
    bus.ret_instr = 32'h00221820;
    tick();
    bus.clear     = 1'b0;
    bus.ret_valid = 1'b0;
    model_reset();
    check_all("clear_frozen");

    // NOP vs SLL with idle cycles in between
    bus.ret_pc    = 32'h104;
    bus.ret_instr = 32'h00221820;
    retire(32'h100, 32'h00000000, 32'h0);
    tick();
    tick();
    retire(32'h104, 32'h00021080, 32'h4);
    check_all("nop_sll");

    // Ordinary J, then J to self
    do_clear();
    retire(32'h38, 32'h00221820, 32'h5);
    retire(32'h3C, 32'h08000020, 32'h0);
    check_flags("jmp_other");
    retire(32'h40, 32'h08000010, 32'h0);
    check_all("self_jmp");
    retire(32'h44, 32'h8C220004, 32'h7);
    check_all("after_self_jmp");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
